modbus_scan_sched: RTL and testbench

MODBUS_SCAN_SCHED -- requirements
Module: modbus_scan_sched

---
 rtl/modbus_scan_sched.sv | 162 ++++++++++++++++
 tb/tb_modbus_scan_sched.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/modbus_scan_sched.sv
// Modbus scan scheduler: walks a scan table, issues one request per entry,
// retries failed entries, and idles scan_period_ms between table passes.
// Optional response timeout is built when MODBUS_SCAN_TIMEOUT_EN is defined;
// without it WAIT_RSP is left only on rsp_v and TO_MS has no effect.
module modbus_scan_sched #(
  parameter int SCAN_MAX   = 16,
  parameter int CLK_PER_MS = 50000,
  parameter int TO_MS      = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scan_en,
  input  logic [7:0]  scan_count,
  input  logic [15:0] scan_period_ms,
  input  logic [3:0]  scan_retry_max,
  output logic [7:0]  ent_idx,
  input  logic [7:0]  ent_slave,
  input  logic [7:0]  ent_func,
  input  logic [15:0] ent_addr,
  input  logic [15:0] ent_qty,
  output logic        req_v,
  input  logic        req_rdy,
  output logic [7:0]  req_slave,
  output logic [7:0]  req_func,
  output logic [15:0] req_addr,
  output logic [15:0] req_qty,
  input  logic        rsp_v,
  input  logic        rsp_ok,
  output logic        busy,
  output logic [15:0] scan_cycles_done,
  output logic [15:0] scan_err_count
);

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_LOAD        = 3'd1;
  localparam logic [2:0] S_ISSUE       = 3'd2;
  localparam logic [2:0] S_WAIT_RSP    = 3'd3;
  localparam logic [2:0] S_NEXT        = 3'd4;
  localparam logic [2:0] S_WAIT_PERIOD = 3'd5;

  localparam int             PW       = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [PW-1:0]  PRE_LAST = PW'(CLK_PER_MS - 1);
  localparam logic [8:0]     SMAX     = 9'(SCAN_MAX);

  logic [2:0]    state;
  logic [3:0]    retry;
  logic [PW-1:0] presc;
  logic [15:0]   per_cnt;
  logic [8:0]    eff_cnt;
  logic          tick, last_ent, per_done, to_hit, rsp_fail, hs;

  assign eff_cnt  = ({1'b0, scan_count} > SMAX) ? SMAX : {1'b0, scan_count};
  assign tick     = (presc == PRE_LAST);
  // eff_cnt may shrink mid-pass; anything at or past the end closes the pass
  assign last_ent = ({1'b0, ent_idx} + 9'd1) >= eff_cnt;
  assign per_done = (scan_period_ms == 16'd0) ||
                    (tick && (({1'b0, per_cnt} + 17'd1) >= {1'b0, scan_period_ms}));
  assign hs       = (state == S_ISSUE) && req_rdy;
  assign req_v    = (state == S_ISSUE);
  assign busy     = (state != S_IDLE);

`ifdef MODBUS_SCAN_TIMEOUT_EN
  logic [15:0] to_cnt;
  assign to_hit = tick && (({16'd0, to_cnt} + 32'd1) >= 32'(TO_MS));

  // response timeout in ms ticks, restarted at every request handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            to_cnt <= '0;
    else if (hs)                           to_cnt <= '0;
    else if (state == S_WAIT_RSP && tick)  to_cnt <= to_cnt + 16'd1;
  end
`else
  assign to_hit = 1'b0;
`endif

  // a response pulse wins over a timeout landing in the same cycle
  assign rsp_fail = (state == S_WAIT_RSP) && (rsp_v ? !rsp_ok : to_hit);

  // ms prescaler; restarted when entering WAIT_RSP (handshake) or leaving NEXT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    presc <= '0;
    else if (hs || state == S_NEXT) presc <= '0;
    else if (tick)                 presc <= '0;
    else                           presc <= presc + 1'b1;
  end

  // idle-gap ms counter for WAIT_PERIOD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              per_cnt <= '0;
    else if (state == S_NEXT)                per_cnt <= '0;
    else if (state == S_WAIT_PERIOD && tick) per_cnt <= per_cnt + 16'd1;
  end

  // scan sequencing, request registers, retry and statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      ent_idx          <= '0;
      retry            <= '0;
      req_slave        <= '0;
      req_func         <= '0;
      req_addr         <= '0;
      req_qty          <= '0;
      scan_cycles_done <= '0;
      scan_err_count   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          ent_idx <= '0;
          if (scan_en && eff_cnt != 9'd0) state <= S_LOAD;
        end
        S_LOAD: begin
          req_slave <= ent_slave;
          req_func  <= ent_func;
          req_addr  <= ent_addr;
          req_qty   <= ent_qty;
          retry     <= '0;
          state     <= S_ISSUE;
        end
        S_ISSUE: begin
          if (req_rdy) state <= S_WAIT_RSP;
        end
        S_WAIT_RSP: begin
          if (rsp_v && rsp_ok) begin
            state <= S_NEXT;
          end else if (rsp_fail) begin
            if (retry < scan_retry_max) begin
              retry <= retry + 4'd1;
              state <= S_ISSUE;
            end else begin
              if (scan_err_count != 16'hFFFF) scan_err_count <= scan_err_count + 16'd1;
              state <= S_NEXT;
            end
          end
        end
        S_NEXT: begin
          if (last_ent) scan_cycles_done <= scan_cycles_done + 16'd1;
          if (!scan_en) begin
            ent_idx <= '0;
            state   <= S_IDLE;
          end else if (last_ent) begin
            ent_idx <= '0;
            state   <= S_WAIT_PERIOD;
          end else begin
            ent_idx <= ent_idx + 8'd1;
            state   <= S_LOAD;
          end
        end
        S_WAIT_PERIOD: begin
          if (!scan_en || eff_cnt == 9'd0) begin
            ent_idx <= '0;
            state   <= S_IDLE;
          end else if (per_done) begin
            state <= S_LOAD;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_modbus_scan_sched.sv
// Bench for modbus_scan_sched: the bench plays scan table and Modbus
// controller; expectations come from a pass/entry/attempt model.
module tb_modbus_scan_sched;
  localparam int SCAN_MAX = 4;
  localparam int CPM      = 10;
  localparam int TOMS     = 5;

  logic        clk = 0, rst_n = 0, scan_en = 0, req_rdy = 0, rsp_v = 0, rsp_ok = 0;
  logic [7:0]  scan_count = 0;
  logic [15:0] scan_period_ms = 0;
  logic [3:0]  scan_retry_max = 0;
  logic [7:0]  ent_idx, ent_slave, ent_func, req_slave, req_func;
  logic [15:0] ent_addr, ent_qty, req_addr, req_qty, scan_cycles_done, scan_err_count;
  logic        req_v, busy;

  logic [7:0]  t_sl [0:255];
  logic [7:0]  t_fn [0:255];
  logic [15:0] t_ad [0:255];
  logic [15:0] t_qt [0:255];

  int total = 0, bad = 0;

  assign ent_slave = t_sl[ent_idx];
  assign ent_func  = t_fn[ent_idx];
  assign ent_addr  = t_ad[ent_idx];
  assign ent_qty   = t_qt[ent_idx];

  modbus_scan_sched #(.SCAN_MAX(SCAN_MAX), .CLK_PER_MS(CPM), .TO_MS(TOMS)) dut (
    .clk(clk), .rst_n(rst_n), .scan_en(scan_en), .scan_count(scan_count),
    .scan_period_ms(scan_period_ms), .scan_retry_max(scan_retry_max),
    .ent_idx(ent_idx), .ent_slave(ent_slave), .ent_func(ent_func),
    .ent_addr(ent_addr), .ent_qty(ent_qty), .req_v(req_v), .req_rdy(req_rdy),
    .req_slave(req_slave), .req_func(req_func), .req_addr(req_addr),
    .req_qty(req_qty), .rsp_v(rsp_v), .rsp_ok(rsp_ok), .busy(busy),
    .scan_cycles_done(scan_cycles_done), .scan_err_count(scan_err_count));

  always #5 clk = ~clk;

  task automatic fill_table();
    for (int i = 0; i < 256; i++) begin
      t_sl[i] = 8'($urandom); t_fn[i] = 8'($urandom);
      t_ad[i] = 16'($urandom); t_qt[i] = 16'($urandom);
    end
  endtask

  task automatic do_reset();
    scan_en = 0; req_rdy = 0; rsp_v = 0; rsp_ok = 0;
    @(negedge clk); rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  // wait for req_v, hold off rdy for dly cycles, then take one transfer
  task automatic wait_hs(input int dly, output bit got, output logic [7:0] idx,
                         output logic [7:0] sl, output logic [7:0] fn,
                         output logic [15:0] ad, output logic [15:0] qt);
    int seen = 0;
    got = 0; idx = 0; sl = 0; fn = 0; ad = 0; qt = 0;
    for (int c = 0; c < 600 && !got; c++) begin
      @(negedge clk);
      if (req_v) begin
        if (seen >= dly) begin
          idx = ent_idx; sl = req_slave; fn = req_func; ad = req_addr; qt = req_qty;
          req_rdy = 1;
          @(negedge clk);
          req_rdy = 0;
          got = 1;
        end
        seen++;
      end
    end
  endtask

  task automatic send_rsp(input bit ok, input int dly);
    repeat (dly) @(negedge clk);
    rsp_v = 1; rsp_ok = ok;
    @(negedge clk);
    rsp_v = 0; rsp_ok = 0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    total++;
    if (req_v !== 1'b0 || busy !== 1'b0 || ent_idx !== 8'd0 || scan_cycles_done !== 16'd0 ||
        scan_err_count !== 16'd0 || req_slave !== 8'd0 || req_addr !== 16'd0) begin
      bad++;
      $display("FAIL reset_state: req_v=%b busy=%b idx=%0d cyc=%0d err=%0d want all 0",
               req_v, busy, ent_idx, scan_cycles_done, scan_err_count);
    end
  endtask

  task automatic test_basic();
    bit got; logic [7:0] idx, sl, fn; logic [15:0] ad, qt; int n;
    do_reset();
    scan_count = 3; scan_period_ms = 0; scan_retry_max = 0; scan_en = 1;
    for (int i = 0; i < 3; i++) begin
      wait_hs(0, got, idx, sl, fn, ad, qt);
      total++;
      if (!got || idx !== 8'(i) || sl !== t_sl[i] || fn !== t_fn[i] || ad !== t_ad[i] || qt !== t_qt[i]) begin
        bad++;
        $display("FAIL basic_req: got=%0b idx=%0d sl=%0h want idx=%0d sl=%0h", got, idx, sl, i, t_sl[i]);
      end
      send_rsp(1, 0);
    end
    n = 1;
    while (!req_v && n < 100) begin @(negedge clk); n++; end
    total++;
    if (n !== 4 || scan_cycles_done !== 16'd1 || ent_idx !== 8'd0) begin
      bad++;
      $display("FAIL basic_wrap: gap=%0d cyc=%0d idx=%0d want gap=4 cyc=1 idx=0", n, scan_cycles_done, ent_idx);
    end
  endtask

  task automatic test_period();
    bit got; logic [7:0] idx, sl, fn; logic [15:0] ad, qt; int n;
    do_reset();
    scan_count = 1; scan_period_ms = 2; scan_retry_max = 0; scan_en = 1;
    wait_hs(0, got, idx, sl, fn, ad, qt);
    send_rsp(1, 2);
    n = 1;
    while (!req_v && n < 200) begin @(negedge clk); n++; end
    total++;
    if (n !== 3 + 2 * CPM || scan_cycles_done !== 16'd1) begin
      bad++;
      $display("FAIL period_gap: gap=%0d cyc=%0d want gap=%0d cyc=1", n, scan_cycles_done, 3 + 2 * CPM);
    end
  endtask

  task automatic test_retry();
    bit got; logic [7:0] idx, sl, fn; logic [15:0] ad, qt;
    do_reset();
    scan_count = 3; scan_period_ms = 0; scan_retry_max = 2; scan_en = 1;
    for (int i = 0; i < 3; i++) begin
      wait_hs(i, got, idx, sl, fn, ad, qt);
      total++;
      if (!got || idx !== 8'd0 || sl !== t_sl[0]) begin
        bad++;
        $display("FAIL retry_idx0: got=%0b idx=%0d attempt=%0d want idx=0", got, idx, i);
      end
      send_rsp(0, 1);
    end
    wait_hs(0, got, idx, sl, fn, ad, qt);
    total++;
    if (!got || idx !== 8'd1 || scan_err_count !== 16'd1) begin
      bad++;
      $display("FAIL retry_exhaust: idx=%0d err=%0d want idx=1 err=1", idx, scan_err_count);
    end
  endtask

  task automatic test_timeout();
    bit got; logic [7:0] idx, sl, fn; logic [15:0] ad, qt;
    do_reset();
    scan_count = 2; scan_period_ms = 0; scan_retry_max = 0; scan_en = 1;
    wait_hs(0, got, idx, sl, fn, ad, qt);
`ifdef MODBUS_SCAN_TIMEOUT_EN
    // first negedge after the handshake edge already passed inside wait_hs
    for (int k = 2; k <= CPM * TOMS + 1; k++) begin
      @(negedge clk);
      if (k == CPM * TOMS) begin
        total++;
        if (scan_err_count !== 16'd0 || req_v !== 1'b0) begin
          bad++;
          $display("FAIL timeout_early: err=%0d req_v=%b want 0 0", scan_err_count, req_v);
        end
      end
    end
    total++;
    if (scan_err_count !== 16'd1) begin
      bad++;
      $display("FAIL timeout_exit: err=%0d want 1", scan_err_count);
    end
`else
    repeat (200) @(negedge clk);
    total++;
    if (scan_err_count !== 16'd0 || busy !== 1'b1 || req_v !== 1'b0) begin
      bad++;
      $display("FAIL no_timeout: err=%0d busy=%b req_v=%b want 0 1 0", scan_err_count, busy, req_v);
    end
    send_rsp(1, 0);
`endif
  endtask

  task automatic test_stall();
    bit got; logic [7:0] idx, sl, fn; logic [15:0] ad, qt; int c = 0; bit ok = 1;
    do_reset();
    scan_count = 2; scan_period_ms = 0; scan_retry_max = 0; scan_en = 1;
    while (!req_v && c < 50) begin @(negedge clk); c++; end
    sl = req_slave; fn = req_func; ad = req_addr; qt = req_qty;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (req_v !== 1'b1 || req_slave !== sl || req_func !== fn || req_addr !== ad || req_qty !== qt) ok = 0;
    end
    total++;
    if (!ok || sl !== t_sl[0] || qt !== t_qt[0]) begin
      bad++;
      $display("FAIL stall_hold: stable=%0b sl=%0h want stable=1 sl=%0h", ok, sl, t_sl[0]);
    end
    req_rdy = 1; @(negedge clk); req_rdy = 0;
    total++;
    if (req_v !== 1'b0) begin
      bad++;
      $display("FAIL stall_drop: req_v=%b want 0", req_v);
    end
    send_rsp(1, 0);
    wait_hs(0, got, idx, sl, fn, ad, qt);
    total++;
    if (!got || idx !== 8'd1) begin
      bad++;
      $display("FAIL stall_next: idx=%0d want 1", idx);
    end
  endtask

  task automatic test_scan_en_drop();
    bit got; logic [7:0] idx, sl, fn; logic [15:0] ad, qt; bit quiet = 1;
    do_reset();
    scan_count = 3; scan_period_ms = 0; scan_retry_max = 0; scan_en = 1;
    wait_hs(0, got, idx, sl, fn, ad, qt);
    scan_en = 0;
    send_rsp(1, 2);
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || ent_idx !== 8'd0) begin
      bad++;
      $display("FAIL en_drop_idle: busy=%b idx=%0d want 0 0", busy, ent_idx);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (req_v !== 1'b0 || busy !== 1'b0) quiet = 0;
    end
    total++;
    if (!quiet) begin
      bad++;
      $display("FAIL en_drop_quiet: activity after disable, want none");
    end
  endtask

  task automatic test_async_reset();
    bit got; logic [7:0] idx, sl, fn; logic [15:0] ad, qt; int c = 0; bit quiet = 1;
    do_reset();
    scan_count = 2; scan_period_ms = 0; scan_retry_max = 0; scan_en = 1;
    wait_hs(0, got, idx, sl, fn, ad, qt);
    send_rsp(0, 0);
    while (!req_v && c < 50) begin @(negedge clk); c++; end
    total++;
    if (req_v !== 1'b1 || scan_err_count !== 16'd1) begin
      bad++;
      $display("FAIL areset_setup: req_v=%b err=%0d want 1 1", req_v, scan_err_count);
    end
    #2 rst_n = 0;
    #1;
    total++;
    if (req_v !== 1'b0 || busy !== 1'b0 || scan_err_count !== 16'd0 ||
        scan_cycles_done !== 16'd0 || ent_idx !== 8'd0) begin
      bad++;
      $display("FAIL areset_async: req_v=%b busy=%b err=%0d cyc=%0d want all 0",
               req_v, busy, scan_err_count, scan_cycles_done);
    end
    scan_en = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (req_v !== 1'b0 || scan_err_count !== 16'd0) quiet = 0;
    end
    total++;
    if (!quiet) begin
      bad++;
      $display("FAIL areset_abandon: request or count after reset, want none");
    end
  endtask

  // random table, count, retries and outcomes against a pass/entry model
  task automatic test_random();
    bit got, ok; logic [7:0] idx, sl, fn; logic [15:0] ad, qt;
    int eff, m_idx = 0, m_try = 0, m_err = 0, m_cyc = 0, rmax;
    fill_table();
    do_reset();
    scan_count = 8'($urandom_range(1, 7));
    rmax = $urandom_range(0, 2);
    scan_retry_max = 4'(rmax);
    scan_period_ms = 16'($urandom_range(0, 1));
    eff = (scan_count > SCAN_MAX) ? SCAN_MAX : int'(scan_count);
    scan_en = 1;
    for (int n = 0; n < 40; n++) begin
      wait_hs($urandom_range(0, 2), got, idx, sl, fn, ad, qt);
      total++;
      if (!got) begin
        bad++;
        $display("FAIL rand_hs_timeout: no request at step %0d", n);
        return;
      end
      total++;
      if (idx !== 8'(m_idx) || sl !== t_sl[m_idx] || fn !== t_fn[m_idx] ||
          ad !== t_ad[m_idx] || qt !== t_qt[m_idx] ||
          scan_err_count !== 16'(m_err) || scan_cycles_done !== 16'(m_cyc)) begin
        bad++;
        $display("FAIL rand_step%0d: idx=%0d err=%0d cyc=%0d want idx=%0d err=%0d cyc=%0d",
                 n, idx, scan_err_count, scan_cycles_done, m_idx, m_err, m_cyc);
      end
      ok = ($urandom_range(0, 9) < 6);
      send_rsp(ok, $urandom_range(0, 3));
      if (!ok && m_try < rmax) m_try++;
      else begin
        if (!ok) m_err++;
        m_try = 0;
        m_idx++;
        if (m_idx == eff) begin m_idx = 0; m_cyc++; end
      end
    end
  endtask

  initial begin
    fill_table();
    test_reset();
    test_basic();
    test_period();
    test_retry();
    test_timeout();
    test_stall();
    test_scan_en_drop();
    test_async_reset();
    for (int r = 0; r < 4; r++) test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
